// File: rtl/stream_config_dispatcher_pkg.sv
// Shared types and constants for the stream/mem config dispatcher.
// - Bus widths of the config write port.
// - Payload types for the type and buffer outputs (select_t is sized by the top).
// - Register offsets relative to BASE_ADDR (8-byte stride).
// - Per-group state encoding.
package stream_config_dispatcher_pkg;

  localparam int unsigned AXI_ADDR_BITS  = 32;
  localparam int unsigned AXIL_DATA_BITS = 64;
  localparam int unsigned TYPE_WIDTH     = 4;

  typedef logic [TYPE_WIDTH-1:0] type_t;

  typedef struct packed {
    logic [63:0] vaddr;
    logic [31:0] size;
  } buffer_t;

  localparam logic [AXI_ADDR_BITS-1:0] CFG_IN_SEL_OFF    = 'h00;
  localparam logic [AXI_ADDR_BITS-1:0] CFG_OUT_SEL_OFF   = 'h08;
  localparam logic [AXI_ADDR_BITS-1:0] CFG_TYPE_OFF      = 'h10;
  localparam logic [AXI_ADDR_BITS-1:0] CFG_BUF_VADDR_OFF = 'h18;
  localparam logic [AXI_ADDR_BITS-1:0] CFG_BUF_SIZE_OFF  = 'h20;
  localparam logic [AXI_ADDR_BITS-1:0] CFG_COMMIT_OFF    = 'h28;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } group_state_t;

endpackage

// File: rtl/stream_config_dispatcher_if.sv
// Bundles used by the config dispatcher.
// config_i      : posted config writes (addr, data, valid), no back-pressure.
//                 s = receiver, m = producer.
// ready_valid_i : generic ready/valid payload channel of Width bits.
//                 m = producer (drives data/valid), s = consumer (drives ready).
interface config_i;
  logic [stream_config_dispatcher_pkg::AXI_ADDR_BITS-1:0]  addr;
  logic [stream_config_dispatcher_pkg::AXIL_DATA_BITS-1:0] data;
  logic                                                    valid;

  modport s (input addr, data, valid);
  modport m (output addr, data, valid);
endinterface

interface ready_valid_i #(
  parameter int unsigned Width = 1
);
  logic [Width-1:0] data;
  logic             valid;
  logic             ready;

  modport m (output data, valid, input ready);
  modport s (input data, valid, output ready);
endinterface

// File: rtl/stream_config_dispatcher_slot.sv
// config_rv_slot: one ready/valid output field.
// Loads payload and raises valid on load_i, holds both stable until ready_i,
// then drops valid. done_o is high when nothing is outstanding after this
// cycle (idle, or handshaking now).
// Ports: clk, rst_n (async active-low), load_i, payload_i, ready_i,
//        valid_o, payload_o, done_o.
module config_rv_slot #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  T     payload_i,
  input  logic ready_i,
  output logic valid_o,
  output T     payload_o,
  output logic done_o
);

  logic valid_q, valid_d;
  T     payload_q, payload_d;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    // Load only happens while the owning group is idle, so it never races a handshake.
    if (load_i) begin
      valid_d   = 1'b1;
      payload_d = payload_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;
  assign done_o    = !valid_q || ready_i;

endmodule

// File: rtl/stream_config_dispatcher.sv
// stream_config_dispatcher: decodes posted config writes into staging registers and
// launches them on ready/valid outputs when COMMIT is written.
// Groups: stream (in_select, out_select, type_o) and mem (buffer), each IDLE/PENDING.
// Ports: clk, rst_n (async active-low), cfg (config_i.s), in_select/out_select/type_o/
//        buffer (ready_valid_i.m), drop_cnt (only with CONFIG_DROP_CNT_EN).
// Optional feature macro: CONFIG_DROP_CNT_EN adds the saturating drop counter and port.
module stream_config_dispatcher
  import stream_config_dispatcher_pkg::*;
#(
  parameter int unsigned              SELECT_WIDTH = 4,
  parameter logic [AXI_ADDR_BITS-1:0] BASE_ADDR    = 'h0,
  parameter int unsigned              CNT_BITS     = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  config_i.s      cfg,
  ready_valid_i.m in_select,
  ready_valid_i.m out_select,
  ready_valid_i.m type_o,
  ready_valid_i.m buffer
`ifdef CONFIG_DROP_CNT_EN
  ,
  output logic [CNT_BITS-1:0] drop_cnt
`endif
);

  typedef logic [SELECT_WIDTH-1:0] select_t;

  if (CNT_BITS < 1) begin : g_cnt_bits_check
    $error("CNT_BITS must be at least 1");
  end

  // Address decode; the lower-bound check keeps the subtraction from wrapping into the window.
  logic [AXI_ADDR_BITS-1:0] off;
  logic hit, wr_in, wr_out, wr_type, wr_vaddr, wr_size, wr_commit;

  assign off       = cfg.addr - BASE_ADDR;
  assign hit       = cfg.valid && (cfg.addr >= BASE_ADDR) && (off <= CFG_COMMIT_OFF) &&
                     (off[2:0] == 3'b000);
  assign wr_in     = hit && (off == CFG_IN_SEL_OFF);
  assign wr_out    = hit && (off == CFG_OUT_SEL_OFF);
  assign wr_type   = hit && (off == CFG_TYPE_OFF);
  assign wr_vaddr  = hit && (off == CFG_BUF_VADDR_OFF);
  assign wr_size   = hit && (off == CFG_BUF_SIZE_OFF);
  assign wr_commit = hit && (off == CFG_COMMIT_OFF);

  group_state_t stream_q, stream_d, mem_q, mem_d;
  logic stream_pend, mem_pend, stream_launch, mem_launch;
  logic in_done, out_done, type_done, buf_done;

  assign stream_pend   = (stream_q == PENDING);
  assign mem_pend      = (mem_q == PENDING);
  assign stream_launch = wr_commit && cfg.data[0] && !stream_pend;
  assign mem_launch    = wr_commit && cfg.data[1] && !mem_pend;

  always_comb begin
    stream_d = stream_q;
    mem_d    = mem_q;
    case (stream_q)
      IDLE:    if (stream_launch) stream_d = PENDING;
      PENDING: if (in_done && out_done && type_done) stream_d = IDLE;
      default: stream_d = IDLE;
    endcase
    case (mem_q)
      IDLE:    if (mem_launch) mem_d = PENDING;
      PENDING: if (buf_done) mem_d = IDLE;
      default: mem_d = IDLE;
    endcase
  end

  // Staging registers; a group's registers are frozen while it is PENDING.
  select_t     in_sel_q, in_sel_d, out_sel_q, out_sel_d;
  type_t       type_q, type_d;
  logic [63:0] vaddr_q, vaddr_d;
  logic [31:0] size_q, size_d;

  always_comb begin
    in_sel_d  = in_sel_q;
    out_sel_d = out_sel_q;
    type_d    = type_q;
    vaddr_d   = vaddr_q;
    size_d    = size_q;
    if (!stream_pend) begin
      if (wr_in)   in_sel_d  = select_t'(cfg.data);
      if (wr_out)  out_sel_d = select_t'(cfg.data);
      if (wr_type) type_d    = type_t'(cfg.data);
    end
    if (!mem_pend) begin
      if (wr_vaddr) vaddr_d = cfg.data;
      if (wr_size)  size_d  = cfg.data[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stream_q  <= IDLE;
      mem_q     <= IDLE;
      in_sel_q  <= '0;
      out_sel_q <= '0;
      type_q    <= '0;
      vaddr_q   <= '0;
      size_q    <= '0;
    end else begin
      stream_q  <= stream_d;
      mem_q     <= mem_d;
      in_sel_q  <= in_sel_d;
      out_sel_q <= out_sel_d;
      type_q    <= type_d;
      vaddr_q   <= vaddr_d;
      size_q    <= size_d;
    end
  end

  buffer_t buf_stage, buf_payload;
  assign buf_stage   = '{vaddr: vaddr_q, size: size_q};
  assign buffer.data = buf_payload;

  config_rv_slot #(.T(select_t)) u_in_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (stream_launch),
    .payload_i (in_sel_q),
    .ready_i   (in_select.ready),
    .valid_o   (in_select.valid),
    .payload_o (in_select.data),
    .done_o    (in_done)
  );

  config_rv_slot #(.T(select_t)) u_out_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (stream_launch),
    .payload_i (out_sel_q),
    .ready_i   (out_select.ready),
    .valid_o   (out_select.valid),
    .payload_o (out_select.data),
    .done_o    (out_done)
  );

  config_rv_slot #(.T(type_t)) u_type_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (stream_launch),
    .payload_i (type_q),
    .ready_i   (type_o.ready),
    .valid_o   (type_o.valid),
    .payload_o (type_o.data),
    .done_o    (type_done)
  );

  config_rv_slot #(.T(buffer_t)) u_buf_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (mem_launch),
    .payload_i (buf_stage),
    .ready_i   (buffer.ready),
    .valid_o   (buffer.valid),
    .payload_o (buf_payload),
    .done_o    (buf_done)
  );

`ifdef CONFIG_DROP_CNT_EN
  // Staging and COMMIT never share a write, so each group adds at most one drop per cycle.
  logic              stream_drop, mem_drop;
  logic [1:0]        drop_inc;
  logic [CNT_BITS:0] cnt_sum;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  assign stream_drop = stream_pend && (wr_in || wr_out || wr_type || (wr_commit && cfg.data[0]));
  assign mem_drop    = mem_pend && (wr_vaddr || wr_size || (wr_commit && cfg.data[1]));
  assign drop_inc    = {1'b0, stream_drop} + {1'b0, mem_drop};

  always_comb begin
    cnt_sum = {1'b0, cnt_q} + (CNT_BITS + 1)'(drop_inc);
    cnt_d   = cnt_sum[CNT_BITS] ? '1 : cnt_sum[CNT_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign drop_cnt = cnt_q;
`endif

endmodule
